// File: rtl/xc_aes_pkg.sv
// Shared definitions for the AES MixColumns initiator: FSM encoding, state
// geometry constants and the ShiftRows/InvShiftRows byte permutation.
package xc_aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam int BYTE_W   = 8;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int COL_W    = BYTE_W * NUM_ROWS;
  localparam int STATE_W  = COL_W * NUM_COLS;
  localparam logic [1:0] LAST_COL = 2'd3;

  // Byte 4c+r holds row r of column c; enc selects ShiftRows, else InvShiftRows.
  function automatic logic [STATE_W-1:0] shift_rows(input logic [STATE_W-1:0] s,
                                                    input logic enc);
    logic [STATE_W-1:0] o;
    int src_c;
    o = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        src_c = enc ? ((c + r) % NUM_COLS) : ((c - r + NUM_COLS) % NUM_COLS);
        o[BYTE_W*(NUM_ROWS*c+r) +: BYTE_W] = s[BYTE_W*(NUM_ROWS*src_c+r) +: BYTE_W];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/xc_aes_shiftrows.sv
// Combinational ShiftRows (enc=1) / InvShiftRows (enc=0) on a 128-bit AES state.
module xc_aes_shiftrows
  import xc_aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic         enc,
  output logic [127:0] state_out
);

  assign state_out = shift_rows(state_in, enc);

endmodule

// File: rtl/xc_aesmix_seq.sv
// Sequences a 128-bit AES state column by column through one MixColumns unit.
// Define XC_AESMIX_SEQ_SHIFTROWS_EN to apply (Inv)ShiftRows to the state on accept.
module xc_aesmix_seq
  import xc_aes_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_enc,
  input  logic [127:0] state_in,
  input  logic         abort,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] state_out,
  output logic         rsp_error,
  output logic         mix_valid,
  output logic         mix_enc,
  output logic [31:0]  mix_rs1,
  output logic [31:0]  mix_rs2,
  output logic         mix_flush,
  input  logic         mix_ready,
  input  logic [31:0]  mix_result
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  localparam bit         TIMEOUT_EN  = (TIMEOUT != 0);

  seq_state_e         state_reg, state_next;
  logic [1:0]         col_reg, col_next;
  logic [7:0]         tcnt_reg, tcnt_next;
  logic [STATE_W-1:0] work_reg, work_next;
  logic               enc_reg, enc_next;
  logic               err_reg, err_next;
  logic               rsp_valid_reg;
  logic               rsp_error_reg;
  logic [STATE_W-1:0] state_out_reg;

  logic [STATE_W-1:0] latch_state;
  logic [COL_W-1:0]   col_words [NUM_COLS];
  logic [7:0]         tcnt_inc;
  logic               timeout_hit;

`ifdef XC_AESMIX_SEQ_SHIFTROWS_EN
  xc_aes_shiftrows u_shiftrows (
    .state_in  (state_in),
    .enc       (req_enc),
    .state_out (latch_state)
  );
`else
  assign latch_state = state_in;
`endif

  generate
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
      assign col_words[gi] = work_reg[COL_W*gi +: COL_W];
    end
  endgenerate

  assign tcnt_inc    = tcnt_reg + 8'd1;
  assign timeout_hit = TIMEOUT_EN && (tcnt_inc == TIMEOUT_CNT);

  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    tcnt_next  = tcnt_reg;
    work_next  = work_reg;
    enc_next   = enc_reg;
    err_next   = err_reg;
    req_ready  = 1'b0;
    mix_valid  = 1'b0;
    mix_flush  = 1'b0;
    mix_rs1    = '0;
    mix_rs2    = '0;
    unique case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !abort) begin
          work_next  = latch_state;
          enc_next   = req_enc;
          col_next   = 2'd0;
          tcnt_next  = 8'd0;
          err_next   = 1'b0;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mix_rs1 = col_words[col_reg];
        mix_rs2 = col_words[col_reg];
        if (abort) begin
          mix_flush  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          mix_valid = 1'b1;
          // A result arriving on the expiry cycle still wins over the timeout.
          if (mix_ready) begin
            work_next[COL_W*col_reg +: COL_W] = mix_result;
            state_next = ST_FLUSH;
          end else begin
            tcnt_next = tcnt_inc;
            if (timeout_hit) begin
              err_next   = 1'b1;
              state_next = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        mix_flush = 1'b1;
        if (abort) begin
          state_next = ST_IDLE;
        end else if (err_reg || (col_reg == LAST_COL)) begin
          state_next = ST_DONE;
        end else begin
          col_next   = col_reg + 2'd1;
          tcnt_next  = 8'd0;
          state_next = ST_ISSUE;
        end
      end
      ST_DONE: begin
        if (abort || (rsp_valid_reg && rsp_ready)) begin
          err_next   = 1'b0;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      col_reg   <= 2'd0;
      tcnt_reg  <= 8'd0;
      work_reg  <= '0;
      enc_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      tcnt_reg  <= tcnt_next;
      work_reg  <= work_next;
      enc_reg   <= enc_next;
      err_reg   <= err_next;
    end
  end

  // Response is registered from the first DONE cycle and held until consumed.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rsp_valid_reg <= 1'b0;
      rsp_error_reg <= 1'b0;
      state_out_reg <= '0;
    end else if (state_reg == ST_DONE) begin
      if (abort || (rsp_valid_reg && rsp_ready)) begin
        rsp_valid_reg <= 1'b0;
        rsp_error_reg <= 1'b0;
      end else if (!rsp_valid_reg) begin
        rsp_valid_reg <= 1'b1;
        rsp_error_reg <= err_reg;
        state_out_reg <= work_reg;
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_error = rsp_error_reg;
  assign state_out = state_out_reg;
  assign mix_enc   = enc_reg;

endmodule

// File: tb/tb_xc_aesmix_seq.sv
// Directed table-driven bench for xc_aesmix_seq with a behavioural MixColumns
// unit whose ready delay is programmable (1, 4, 15 cycles or never).
module tb_xc_aesmix_seq;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_enc = 1'b0;
  logic [127:0] state_in = '0;
  logic         abort = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] state_out;
  logic         rsp_error;
  logic         mix_valid, mix_enc, mix_flush, mix_ready;
  logic [31:0]  mix_rs1, mix_rs2, mix_result;

  // Second instance with the timeout disabled and a unit that never answers.
  logic         n_req_valid = 1'b0;
  logic         n_req_ready, n_rsp_valid, n_rsp_error;
  logic [127:0] n_state_out;
  logic         n_mix_valid, n_mix_enc, n_mix_flush;
  logic [31:0]  n_mix_rs1, n_mix_rs2;

  int tests = 0;
  int fails = 0;

  int mdelay = 1;
  bit mident = 1'b0;
  int mcnt = 0;
  int flush_cnt = 0;
  int issue_cnt = 0;
  int stab_err = 0;
  bit prev_v = 1'b0;
  logic [31:0] prev_rs1 = '0;

  xc_aesmix_seq #(.TIMEOUT(15)) dut (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_enc(req_enc), .state_in(state_in), .abort(abort), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .state_out(state_out), .rsp_error(rsp_error),
    .mix_valid(mix_valid), .mix_enc(mix_enc), .mix_rs1(mix_rs1), .mix_rs2(mix_rs2),
    .mix_flush(mix_flush), .mix_ready(mix_ready), .mix_result(mix_result)
  );

  xc_aesmix_seq #(.TIMEOUT(0)) dut_nt (
    .clock(clock), .resetn(resetn), .req_valid(n_req_valid), .req_ready(n_req_ready),
    .req_enc(1'b1), .state_in(128'h0123), .abort(1'b0), .rsp_valid(n_rsp_valid),
    .rsp_ready(1'b1), .state_out(n_state_out), .rsp_error(n_rsp_error),
    .mix_valid(n_mix_valid), .mix_enc(n_mix_enc), .mix_rs1(n_mix_rs1), .mix_rs2(n_mix_rs2),
    .mix_flush(n_mix_flush), .mix_ready(1'b0), .mix_result(32'h0)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] w, input logic enc);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] o0, o1, o2, o3;
    a0 = w[7:0]; a1 = w[15:8]; a2 = w[23:16]; a3 = w[31:24];
    if (enc) begin
      o0 = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
      o1 = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
      o2 = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
      o3 = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
    end else begin
      o0 = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
      o1 = gmul(a0, 8'd9) ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
      o2 = gmul(a0, 8'd13) ^ gmul(a1, 8'd9) ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
      o3 = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9) ^ gmul(a3, 8'd14);
    end
    return {o3, o2, o1, o0};
  endfunction

  // Behavioural mix unit: ready on the mdelay-th valid cycle, flush restarts it.
  assign mix_ready  = mix_valid && (mdelay != 0) && (mcnt == mdelay - 1);
  assign mix_result = mident ? mix_rs1 : mixcol(mix_rs1, mix_enc);

  always @(posedge clock) begin
    if (mix_flush) mcnt <= 0;
    else if (mix_valid && !mix_ready) mcnt <= mcnt + 1;
    if (mix_flush) flush_cnt <= flush_cnt + 1;
    if (mix_valid) issue_cnt <= issue_cnt + 1;
  end

  always @(negedge clock) begin
    if (mix_valid && ((mix_rs1 !== mix_rs2) || (prev_v && (mix_rs1 !== prev_rs1))))
      stab_err <= stab_err + 1;
    prev_v   <= mix_valid;
    prev_rs1 <= mix_rs1;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [127:0] st;
    logic         enc;
    int           delay;
    bit           ident;
    int           lat;
    logic [127:0] exp;
    logic         err;
    int           flushes;
    int           issues;
    int           hold;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [127:0] st, input logic enc, input int delay,
                              input bit ident, input int lat, input logic [127:0] exp,
                              input logic err, input int flushes, input int issues,
                              input int hold);
    vec_t v;
    v.st = st; v.enc = enc; v.delay = delay; v.ident = ident; v.lat = lat;
    v.exp = exp; v.err = err; v.flushes = flushes; v.issues = issues; v.hold = hold;
    return v;
  endfunction

  task automatic run_req(input vec_t v, input int idx);
    int lat;
    mdelay = v.delay;
    mident = v.ident;
    @(negedge clock);
    state_in  = v.st;
    req_enc   = v.enc;
    req_valid = 1'b1;
    chk($sformatf("v%0d req_ready idle", idx), 128'(req_ready), 128'(1));
    @(posedge clock);
    flush_cnt = 0;
    issue_cnt = 0;
    stab_err  = 0;
    #1 req_valid = 1'b0;
    lat = 0;
    while ((rsp_valid !== 1'b1) && (lat < 200)) begin
      @(posedge clock);
      #1 lat++;
    end
    $display("[TB] vec %0d enc=%0d delay=%0d lat=%0d out=%h err=%0d", idx, v.enc, v.delay,
             lat, state_out, rsp_error);
    chk($sformatf("v%0d latency", idx), 128'(lat), 128'(v.lat));
    chk($sformatf("v%0d state_out", idx), state_out, v.exp);
    chk($sformatf("v%0d rsp_error", idx), 128'(rsp_error), 128'(v.err));
    chk($sformatf("v%0d flush pulses", idx), 128'(flush_cnt), 128'(v.flushes));
    chk($sformatf("v%0d issue cycles", idx), 128'(issue_cnt), 128'(v.issues));
    chk($sformatf("v%0d operand stability", idx), 128'(stab_err), 128'(0));
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clock);
      chk($sformatf("v%0d hold rsp_valid", idx), 128'(rsp_valid), 128'(1));
      chk($sformatf("v%0d hold state_out", idx), state_out, v.exp);
      chk($sformatf("v%0d hold req_ready", idx), 128'(req_ready), 128'(0));
    end
    @(negedge clock);
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
    chk($sformatf("v%0d rsp_valid after ack", idx), 128'(rsp_valid), 128'(0));
    chk($sformatf("v%0d req_ready after ack", idx), 128'(req_ready), 128'(1));
  endtask

  initial begin
    int cyc;
    bit seen;

    vecs.push_back(mk({4{32'h455313db}}, 1'b1, 1, 1'b0, 9, {4{32'hbca14d8e}}, 1'b0, 4, 4, 5));
    vecs.push_back(mk({4{32'hbca14d8e}}, 1'b0, 4, 1'b0, 21, {4{32'h455313db}}, 1'b0, 4, 16, 0));
`ifndef XC_AESMIX_SEQ_SHIFTROWS_EN
    vecs.push_back(mk({32'h01010101, 32'h5c220af2, 32'h01010101, 32'h5c220af2}, 1'b1, 1, 1'b0, 9,
                      {32'h01010101, 32'h9d58dc9f, 32'h01010101, 32'h9d58dc9f}, 1'b0, 4, 4, 5));
    vecs.push_back(mk({32'h9d58dc9f, 32'h01010101, 32'h9d58dc9f, 32'h01010101}, 1'b0, 4, 1'b0, 21,
                      {32'h5c220af2, 32'h01010101, 32'h5c220af2, 32'h01010101}, 1'b0, 4, 16, 0));
`else
    vecs.push_back(mk(128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b1, 1, 1'b1, 9,
                      128'h0b06010c_07020d08_030e0904_0f0a0500, 1'b0, 4, 4, 0));
    vecs.push_back(mk(128'h0b06010c_07020d08_030e0904_0f0a0500, 1'b0, 1, 1'b1, 9,
                      128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b0, 4, 4, 0));
`endif
    // Unit never ready: 15 ISSUE cycles, one FLUSH, error response.
    vecs.push_back(mk({4{32'h11223344}}, 1'b1, 0, 1'b0, 17, {4{32'h11223344}}, 1'b1, 1, 15, 0));
    // Ready lands on the same cycle the timeout would expire: no error.
    vecs.push_back(mk({4{32'h455313db}}, 1'b1, 15, 1'b0, 65, {4{32'hbca14d8e}}, 1'b0, 4, 60, 0));

    repeat (3) @(negedge clock);
    chk("reset rsp_valid", 128'(rsp_valid), 128'(0));
    chk("reset rsp_error", 128'(rsp_error), 128'(0));
    chk("reset mix_valid", 128'(mix_valid), 128'(0));
    chk("reset mix_flush", 128'(mix_flush), 128'(0));
    chk("reset mix_rs1", 128'(mix_rs1), 128'(0));
    chk("reset state_out", state_out, 128'(0));
    chk("reset req_ready", 128'(req_ready), 128'(1));
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < vecs.size(); i++) run_req(vecs[i], i);

    // abort in IDLE beats req_valid
    @(negedge clock);
    state_in = {4{32'h455313db}};
    req_enc = 1'b1;
    req_valid = 1'b1;
    abort = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    abort = 1'b0;
    $display("[TB] abort-in-idle req_ready=%0d mix_valid=%0d", req_ready, mix_valid);
    chk("idle abort req_ready", 128'(req_ready), 128'(1));
    chk("idle abort mix_valid", 128'(mix_valid), 128'(0));

    // abort during column 2 ISSUE with the 4-cycle unit
    mdelay = 4;
    mident = 1'b0;
    @(negedge clock);
    req_valid = 1'b1;
    @(posedge clock);
    flush_cnt = 0;
    #1 req_valid = 1'b0;
    cyc = 0;
    while (!((flush_cnt == 2) && mix_valid) && (cyc < 100)) begin
      @(negedge clock);
      cyc++;
    end
    chk("abort reached col2", 128'(mix_rs1 !== 32'h455313db || flush_cnt != 2), 128'(0));
    abort = 1'b1;
    #1;
    chk("abort mix_flush", 128'(mix_flush), 128'(1));
    chk("abort mix_valid", 128'(mix_valid), 128'(0));
    @(posedge clock);
    #1 abort = 1'b0;
    chk("abort to idle", 128'(req_ready), 128'(1));
    seen = 1'b0;
    repeat (30) begin
      @(negedge clock);
      if (rsp_valid) seen = 1'b1;
    end
    $display("[TB] abort-in-issue rsp_seen=%0d", seen);
    chk("abort no response", 128'(seen), 128'(0));
    run_req(mk({4{32'h455313db}}, 1'b1, 4, 1'b0, 21, {4{32'hbca14d8e}}, 1'b0, 4, 16, 0), 90);

    // abort in DONE drops the response
    mdelay = 1;
    @(negedge clock);
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    cyc = 0;
    while ((rsp_valid !== 1'b1) && (cyc < 50)) begin
      @(negedge clock);
      cyc++;
    end
    chk("done reached", 128'(rsp_valid), 128'(1));
    abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    $display("[TB] abort-in-done rsp_valid=%0d req_ready=%0d", rsp_valid, req_ready);
    chk("done abort rsp_valid", 128'(rsp_valid), 128'(0));
    chk("done abort req_ready", 128'(req_ready), 128'(1));

    // TIMEOUT = 0 instance never answers
    @(negedge clock);
    n_req_valid = 1'b1;
    @(posedge clock);
    #1 n_req_valid = 1'b0;
    seen = 1'b0;
    repeat (300) begin
      @(negedge clock);
      if (n_rsp_valid) seen = 1'b1;
    end
    $display("[TB] no-timeout rsp_seen=%0d mix_valid=%0d", seen, n_mix_valid);
    chk("no-timeout no response", 128'(seen), 128'(0));
    chk("no-timeout still issuing", 128'(n_mix_valid), 128'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
